// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants for the register-file writeback arbiter
package regfile_pkg;

  // Default architectural register count and datapath width
  localparam int DEFAULT_COUNT     = 32;
  localparam int DEFAULT_BUS_WIDTH = 32;

  // Hard-wired $zero register address; writes to it are consumed but never issued
  localparam int REG_ZERO = 0;

  // Writeback source indices, also the encoding of the round-robin last-grant register
  localparam logic SRC_EX = 1'b0;
  localparam logic SRC_MC = 1'b1;

endpackage

// File: rtl/rf_wb_buffer.sv
// rtl/rf_wb_buffer.sv - one-entry writeback holding buffer with valid/ready intake
module rf_wb_buffer #(
  parameter int ADDR_WIDTH = 5,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  input  logic [BUS_WIDTH-1:0]  in_data_i,
  output logic                  in_ready_o,
  input  logic                  release_i,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [BUS_WIDTH-1:0]  data_o
);

  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0]  data_q, data_d;
  logic                  accept;

  // Ready when empty, or when the current entry is leaving this cycle; release_i
  // comes from registered state only, so ready never depends on in_valid_i.
  assign in_ready_o = ~valid_q | release_i;
  assign accept     = in_valid_i & in_ready_o;

  // Next-state: a new capture wins over a release so a same-cycle refill keeps the entry valid
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (accept) begin
      valid_d = 1'b1;
      addr_d  = in_addr_i;
      data_d  = in_data_i;
    end else if (release_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry registers; reset discards whatever was held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin share of the register-file write port with RAW hazard flags
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter  int COUNT      = DEFAULT_COUNT,
  parameter  int BUS_WIDTH  = DEFAULT_BUS_WIDTH,
  localparam int ADDR_WIDTH = $clog2(COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src0_valid,
  input  logic [ADDR_WIDTH-1:0] src0_addr,
  input  logic [BUS_WIDTH-1:0]  src0_data,
  output logic                  src0_ready,
  input  logic                  src1_valid,
  input  logic [ADDR_WIDTH-1:0] src1_addr,
  input  logic [BUS_WIDTH-1:0]  src1_data,
  output logic                  src1_ready,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [BUS_WIDTH-1:0]  rf_data_in,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  logic                  buf0_valid, buf1_valid;
  logic [ADDR_WIDTH-1:0] buf0_addr, buf1_addr;
  logic [BUS_WIDTH-1:0]  buf0_data, buf1_data;
  logic                  grant0, grant1;

  logic                  last_grant_q, last_grant_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [BUS_WIDTH-1:0]  wr_data_q, wr_data_d;

  rf_wb_buffer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BUS_WIDTH (BUS_WIDTH)
  ) u_buf_ex (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid_i(src0_valid),
    .in_addr_i (src0_addr),
    .in_data_i (src0_data),
    .in_ready_o(src0_ready),
    .release_i (grant0),
    .valid_o   (buf0_valid),
    .addr_o    (buf0_addr),
    .data_o    (buf0_data)
  );

  rf_wb_buffer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BUS_WIDTH (BUS_WIDTH)
  ) u_buf_mc (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid_i(src1_valid),
    .in_addr_i (src1_addr),
    .in_data_i (src1_data),
    .in_ready_o(src1_ready),
    .release_i (grant1),
    .valid_o   (buf1_valid),
    .addr_o    (buf1_addr),
    .data_o    (buf1_data)
  );

  // Round-robin grant from registered buffer state: a lone buffer always wins,
  // on contention the source that was not granted last goes first.
  always_comb begin
    grant0 = buf0_valid & (~buf1_valid | (last_grant_q == SRC_MC));
    grant1 = buf1_valid & (~buf0_valid | (last_grant_q == SRC_EX));
  end

  // Issue next-state: $zero writes drain the buffer and advance round-robin but never assert wr_en
  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (grant0) begin
      last_grant_d = SRC_EX;
      wr_en_d      = (buf0_addr != ZERO_ADDR);
      wr_addr_d    = buf0_addr;
      wr_data_d    = buf0_data;
    end else if (grant1) begin
      last_grant_d = SRC_MC;
      wr_en_d      = (buf1_addr != ZERO_ADDR);
      wr_addr_d    = buf1_addr;
      wr_data_d    = buf1_data;
    end
  end

  // Registered write-port drives; reset primes last_grant so src0 wins the first contention
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= SRC_MC;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign rf_wr_en      = wr_en_q;
  assign rf_write_addr = wr_addr_q;
  assign rf_data_in    = wr_data_q;

  // A read address is hazardous while any buffered or in-flight write targets it;
  // requests arriving this cycle are deliberately not looked at.
  function automatic logic write_pending(
    input logic [ADDR_WIDTH-1:0] ra,
    input logic                  v0,
    input logic [ADDR_WIDTH-1:0] a0,
    input logic                  v1,
    input logic [ADDR_WIDTH-1:0] a1,
    input logic                  vw,
    input logic [ADDR_WIDTH-1:0] aw
  );
    return (ra != ZERO_ADDR) &
           ((v0 & (a0 == ra)) | (v1 & (a1 == ra)) | (vw & (aw == ra)));
  endfunction

  // Hazard flags for the two decode read ports
  always_comb begin
    hazard1 = write_pending(read_addr1, buf0_valid, buf0_addr, buf1_valid, buf1_addr,
                            wr_en_q, wr_addr_q);
    hazard2 = write_pending(read_addr2, buf0_valid, buf0_addr, buf1_valid, buf1_addr,
                            wr_en_q, wr_addr_q);
  end

  assign busy = buf0_valid | buf1_valid | wr_en_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        src0_valid;
  logic [4:0]  src0_addr;
  logic [31:0] src0_data;
  logic        src0_ready;
  logic        src1_valid;
  logic [4:0]  src1_addr;
  logic [31:0] src1_data;
  logic        src1_ready;
  logic        rf_wr_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_data_in;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic        hazard1;
  logic        hazard2;
  logic        busy;

  int checks;
  int failures;

  regfile_write_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src0_valid   (src0_valid),
    .src0_addr    (src0_addr),
    .src0_data    (src0_data),
    .src0_ready   (src0_ready),
    .src1_valid   (src1_valid),
    .src1_addr    (src1_addr),
    .src1_data    (src1_data),
    .src1_ready   (src1_ready),
    .rf_wr_en     (rf_wr_en),
    .rf_write_addr(rf_write_addr),
    .rf_data_in   (rf_data_in),
    .read_addr1   (read_addr1),
    .read_addr2   (read_addr2),
    .hazard1      (hazard1),
    .hazard2      (hazard2),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    src0_valid = 1'b0;
    src0_addr  = '0;
    src0_data  = '0;
    src1_valid = 1'b0;
    src1_addr  = '0;
    src1_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    read_addr1 = '0;
    read_addr2 = '0;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    do_reset();

    // Reset state
    check("rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
    check("rst_addr", {27'd0, rf_write_addr}, 32'd0);
    check("rst_data", rf_data_in, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready0", {31'd0, src0_ready}, 32'd1);
    check("rst_ready1", {31'd0, src1_ready}, 32'd1);

    // Single src0 write: wr_en exactly two cycles after the handshake
    src0_valid = 1'b1; src0_addr = 5'd5; src0_data = 32'hDEADBEEF;
    #1;
    check("t1_ready0", {31'd0, src0_ready}, 32'd1);
    tick();
    idle_inputs();
    #1;
    check("t1_c1_wr_en", {31'd0, rf_wr_en}, 32'd0);
    check("t1_c1_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t1_c2_wr_en", {31'd0, rf_wr_en}, 32'd1);
    check("t1_c2_addr", {27'd0, rf_write_addr}, 32'd5);
    check("t1_c2_data", rf_data_in, 32'hDEADBEEF);
    tick();
    check("t1_c3_wr_en", {31'd0, rf_wr_en}, 32'd0);
    check("t1_c3_addr_hold", {27'd0, rf_write_addr}, 32'd5);
    check("t1_c3_busy", {31'd0, busy}, 32'd0);

    // Contention from reset: src0 first, then src1; a src0 refill then loses to src1
    do_reset();
    src0_valid = 1'b1; src0_addr = 5'd3; src0_data = 32'h11;
    src1_valid = 1'b1; src1_addr = 5'd4; src1_data = 32'h22;
    #1;
    check("t2_ready0", {31'd0, src0_ready}, 32'd1);
    check("t2_ready1", {31'd0, src1_ready}, 32'd1);
    tick();
    idle_inputs();
    src0_valid = 1'b1; src0_addr = 5'd9; src0_data = 32'h99;
    #1;
    check("t2_refill_ready0", {31'd0, src0_ready}, 32'd1);
    check("t2_blocked_ready1", {31'd0, src1_ready}, 32'd0);
    tick();
    idle_inputs();
    #1;
    check("t2_w1_wr_en", {31'd0, rf_wr_en}, 32'd1);
    check("t2_w1_addr", {27'd0, rf_write_addr}, 32'd3);
    check("t2_w1_data", rf_data_in, 32'h11);
    tick();
    check("t2_w2_wr_en", {31'd0, rf_wr_en}, 32'd1);
    check("t2_w2_addr", {27'd0, rf_write_addr}, 32'd4);
    check("t2_w2_data", rf_data_in, 32'h22);
    tick();
    check("t2_w3_wr_en", {31'd0, rf_wr_en}, 32'd1);
    check("t2_w3_addr", {27'd0, rf_write_addr}, 32'd9);
    check("t2_w3_data", rf_data_in, 32'h99);
    tick();
    check("t2_end_wr_en", {31'd0, rf_wr_en}, 32'd0);
    check("t2_end_busy", {31'd0, busy}, 32'd0);

    // $zero write from src1 is consumed without a register-file write
    src1_valid = 1'b1; src1_addr = 5'd0; src1_data = 32'hFFFFFFFF;
    #1;
    check("t3_ready1", {31'd0, src1_ready}, 32'd1);
    tick();
    idle_inputs();
    #1;
    check("t3_c1_wr_en", {31'd0, rf_wr_en}, 32'd0);
    check("t3_c1_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t3_c2_wr_en", {31'd0, rf_wr_en}, 32'd0);
    check("t3_c2_busy", {31'd0, busy}, 32'd0);
    check("t3_c2_data", rf_data_in, 32'hFFFFFFFF);
    tick();
    check("t3_c3_wr_en", {31'd0, rf_wr_en}, 32'd0);

    // Back-to-back src0 stream, addresses 1..8, one write per cycle
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        src0_valid = 1'b1;
        src0_addr  = 5'(k + 1);
        src0_data  = 32'h100 + 32'(k + 1);
      end else begin
        idle_inputs();
      end
      #1;
      if (k < 8) check($sformatf("t4_ready0_%0d", k), {31'd0, src0_ready}, 32'd1);
      if (k >= 2) begin
        check($sformatf("t4_wr_en_%0d", k), {31'd0, rf_wr_en}, 32'd1);
        check($sformatf("t4_addr_%0d", k), {27'd0, rf_write_addr}, 32'(k - 1));
        check($sformatf("t4_data_%0d", k), rf_data_in, 32'h100 + 32'(k - 1));
      end
      tick();
    end
    check("t4_end_wr_en", {31'd0, rf_wr_en}, 32'd0);

    // RAW hazard tracks the write through the buffer and then the write port
    read_addr1 = 5'd7; read_addr2 = 5'd0;
    src0_valid = 1'b1; src0_addr = 5'd7; src0_data = 32'h77;
    #1;
    check("t5_c0_hazard1", {31'd0, hazard1}, 32'd0);
    check("t5_c0_hazard2", {31'd0, hazard2}, 32'd0);
    tick();
    idle_inputs();
    #1;
    check("t5_c1_hazard1", {31'd0, hazard1}, 32'd1);
    check("t5_c1_hazard2", {31'd0, hazard2}, 32'd0);
    tick();
    check("t5_c2_hazard1", {31'd0, hazard1}, 32'd1);
    check("t5_c2_hazard2", {31'd0, hazard2}, 32'd0);
    check("t5_c2_wr_en", {31'd0, rf_wr_en}, 32'd1);
    tick();
    check("t5_c3_hazard1", {31'd0, hazard1}, 32'd0);
    check("t5_c3_hazard2", {31'd0, hazard2}, 32'd0);
    read_addr1 = '0;

    // Reset with both buffers full drops both pending writes
    src0_valid = 1'b1; src0_addr = 5'd13; src0_data = 32'hAAAA;
    src1_valid = 1'b1; src1_addr = 5'd14; src1_data = 32'hBBBB;
    tick();
    idle_inputs();
    #1;
    check("t6_full_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_r_wr_en", {31'd0, rf_wr_en}, 32'd0);
    check("t6_r_busy", {31'd0, busy}, 32'd0);
    check("t6_r_ready0", {31'd0, src0_ready}, 32'd1);
    check("t6_r_ready1", {31'd0, src1_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t6_post_wr_en_%0d", k), {31'd0, rf_wr_en}, 32'd0);
      check($sformatf("t6_post_busy_%0d", k), {31'd0, busy}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
